// File: rtl/usb_bit_unstuffer.sv
// USB receive bit unstuffer.
// Forwards the first PID_BITS bits of a packet untouched, then removes the bit that
// follows every run of STUFF_LEN ones. The output is a gapped valid/bit stream with a
// one-cycle end-of-packet pulse.
// Optional feature macro USB_UNSTUFF_ERR_CHECK_EN: a 1 in the stuff-bit slot raises a
// sticky stuff_err and discards the rest of the packet. Without the macro the stuff bit
// is discarded whatever its value and stuff_err is tied low.
module usb_bit_unstuffer #(
  parameter int unsigned PID_BITS  = 8,
  parameter int unsigned STUFF_LEN = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_eop,
  output logic out_valid,
  output logic out_bit,
  output logic out_eop,
  output logic ubs_busy,
  output logic stuff_err
);

  localparam int unsigned BitCntW  = $clog2(PID_BITS + 1);
  localparam int unsigned OnesCntW = $clog2(STUFF_LEN + 1);

  typedef enum logic [2:0] {StIdle, StPid, StData, StDrop, StError} state_e;

  state_e              state_q, state_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [OnesCntW-1:0] ones_cnt_q, ones_cnt_d;
  logic                out_valid_d, out_bit_d, out_eop_d, busy_d, stuff_err_d;
  logic                eop_take;

  // An EOP counts only when a packet is in progress or starts in this very cycle.
  assign eop_take = in_eop && ((state_q != StIdle) || in_valid);

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      ones_cnt_q <= '0;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
      out_eop    <= 1'b0;
      ubs_busy   <= 1'b0;
      stuff_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      out_valid  <= out_valid_d;
      out_bit    <= out_bit_d;
      out_eop    <= out_eop_d;
      ubs_busy   <= busy_d;
      stuff_err  <= stuff_err_d;
    end
  end

  // Next state and counters: process the bit first, then apply the EOP.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    ones_cnt_d = ones_cnt_q;
    if (in_valid) begin
      unique case (state_q)
        StIdle: begin
          bit_cnt_d = BitCntW'(1);
          if (PID_BITS == 1) begin
            ones_cnt_d = OnesCntW'(in_bit);
            state_d    = StData;
          end else begin
            ones_cnt_d = '0;
            state_d    = StPid;
          end
        end
        StPid: begin
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
          // Only the last PID bit seeds the run of ones.
          if (bit_cnt_q == BitCntW'(PID_BITS - 1)) begin
            ones_cnt_d = OnesCntW'(in_bit);
            state_d    = StData;
          end
        end
        StData: begin
          if (!in_bit) begin
            ones_cnt_d = '0;
          end else if (ones_cnt_q == OnesCntW'(STUFF_LEN - 1)) begin
            ones_cnt_d = '0;
            state_d    = StDrop;
          end else begin
            ones_cnt_d = ones_cnt_q + OnesCntW'(1);
          end
        end
        StDrop: begin
`ifdef USB_UNSTUFF_ERR_CHECK_EN
          if (in_bit) begin
            state_d = StError;
          end else begin
            state_d    = StData;
            ones_cnt_d = '0;
          end
`else
          state_d    = StData;
          ones_cnt_d = '0;
`endif
        end
        StError: begin
          state_d = StError;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
    if (eop_take) begin
      state_d    = StIdle;
      bit_cnt_d  = '0;
      ones_cnt_d = '0;
    end
  end

  // Output next values: forward in IDLE/PID/DATA, never in DROP/ERROR.
  always_comb begin
    out_valid_d = in_valid && (state_q inside {StIdle, StPid, StData});
    out_bit_d   = out_valid_d ? in_bit : 1'b0;
    out_eop_d   = eop_take;
    busy_d      = (state_d != StIdle);
`ifdef USB_UNSTUFF_ERR_CHECK_EN
    stuff_err_d = stuff_err;
    if (in_valid && (state_q == StIdle)) begin
      stuff_err_d = 1'b0;
    end else if (in_valid && (state_q == StDrop) && in_bit) begin
      stuff_err_d = 1'b1;
    end
`else
    stuff_err_d = 1'b0;
`endif
  end

endmodule

// File: tb/tb_usb_bit_unstuffer.sv
// Directed, table-driven bench for usb_bit_unstuffer (default parameters).
module tb_usb_bit_unstuffer;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic in_eop = 1'b0;
  logic out_valid, out_bit, out_eop, ubs_busy, stuff_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic  v, b, e;
    logic  ev, eb, ee, busy, err;
    string tag;
  } vec_t;

  vec_t vecs[$];
  logic err_hold = 1'b0;

  always #5 clock = ~clock;

  usb_bit_unstuffer dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_eop   (in_eop),
    .out_valid(out_valid),
    .out_bit  (out_bit),
    .out_eop  (out_eop),
    .ubs_busy (ubs_busy),
    .stuff_err(stuff_err)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic push(input logic v, input logic b, input logic e, input logic ev,
                      input logic eb, input logic ee, input logic busy, input logic err,
                      input string tag);
    vec_t r;
    r.v = v; r.b = b; r.e = e; r.ev = ev; r.eb = eb; r.ee = ee;
    r.busy = busy; r.err = err; r.tag = tag;
    vecs.push_back(r);
  endtask

  // bits/keep are LSB-first: bit i is the i-th wire bit, keep[i] says it is forwarded.
  task automatic add_pkt(input string tag, input logic [31:0] bits, input logic [31:0] keep,
                         input int n, input int gap, input bit eop_with_last,
                         input int err_from);
    for (int i = 0; i < n; i++) begin
      logic le;
      le = eop_with_last && (i == n - 1);
      if (i == 0) err_hold = 1'b0;
      if (err_from >= 0 && i >= err_from) err_hold = 1'b1;
      push(1'b1, bits[i], le, keep[i], bits[i], le, !le, err_hold, tag);
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, err_hold, tag);
      end
    end
    if (!eop_with_last) push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, err_hold, tag);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, err_hold, tag);
  endtask

  task automatic step(input logic v, input logic b, input logic e);
    in_valid = v; in_bit = b; in_eop = e;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset values.
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_bit", out_bit, 1'b0);
    chk("rst_eop", out_eop, 1'b0);
    chk("rst_busy", ubs_busy, 1'b0);
    chk("rst_err", stuff_err, 1'b0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // EOP while idle is ignored.
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_eop");
    // PID 1,0,0,0,0,1,1,1 seeds ones=1; data 1x5 then stuffed 0 dropped, then 1.
    add_pkt("seed", 32'h5FE1, 32'h5FFF, 15, 0, 1'b0, -1);
    // PID ends in 0; data 1x6, stuff 0 dropped, final 0 forwarded.
    add_pkt("data_stuff", 32'h3F5A, 32'hBFFF, 16, 0, 1'b0, -1);
    // Eight ones inside the PID are never unstuffed; last bit carries the EOP.
    add_pkt("pid_ones", 32'h00FF, 32'h01FF, 9, 0, 1'b1, -1);
    // Same stream as "seed" with three idle cycles between bits.
    add_pkt("gapped", 32'h5FE1, 32'h5FFF, 15, 3, 1'b0, -1);
    // EOP while a stuff bit is pending is legal.
    add_pkt("eop_drop", 32'h3F00, 32'h3FFF, 14, 0, 1'b0, -1);
    // PID zeros, data 1x7, then 0,1.
`ifdef USB_UNSTUFF_ERR_CHECK_EN
    add_pkt("violation", 32'h17F00, 32'h3FFF, 17, 0, 1'b0, 14);
`else
    add_pkt("violation", 32'h17F00, 32'h1BFFF, 17, 0, 1'b0, -1);
`endif
    // Next packet clears any held error on its first bit.
    add_pkt("after", 32'h0001, 32'h01FF, 9, 0, 1'b0, -1);

    foreach (vecs[k]) begin
      step(vecs[k].v, vecs[k].b, vecs[k].e);
      chk($sformatf("%s[%0d].valid", vecs[k].tag, k), out_valid, vecs[k].ev);
      if (vecs[k].ev) chk($sformatf("%s[%0d].bit", vecs[k].tag, k), out_bit, vecs[k].eb);
      chk($sformatf("%s[%0d].eop", vecs[k].tag, k), out_eop, vecs[k].ee);
      chk($sformatf("%s[%0d].busy", vecs[k].tag, k), ubs_busy, vecs[k].busy);
      chk($sformatf("%s[%0d].err", vecs[k].tag, k), stuff_err, vecs[k].err);
    end

    // Asynchronous reset while waiting for a stuff bit.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    chk("pre_rst_busy", ubs_busy, 1'b1);
    chk("pre_rst_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_busy", ubs_busy, 1'b0);
    chk("async_rst_err", stuff_err, 1'b0);
    @(posedge clock);
    #1;
    chk("rst_no_eop", out_eop, 1'b0);
    reset_n = 1'b1;
    begin
      logic [7:0] pid;
      pid = 8'b1111_1011;
      for (int i = 0; i < 8; i++) begin
        step(1'b1, pid[i], 1'b0);
        chk($sformatf("post_rst_pid[%0d].valid", i), out_valid, 1'b1);
        chk($sformatf("post_rst_pid[%0d].bit", i), out_bit, pid[i]);
      end
    end
    // Data bit and EOP together.
    step(1'b1, 1'b0, 1'b1);
    chk("sim_valid", out_valid, 1'b1);
    chk("sim_bit", out_bit, 1'b0);
    chk("sim_eop", out_eop, 1'b1);
    chk("sim_busy", ubs_busy, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("sim_eop_one_cycle", out_eop, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
